// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: scanned display bus in, reconstructed frame out
interface seg7_scan_reader_if;
    logic [3:0]  an;
    logic [6:0]  LED;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        frame_valid;
    modport master (output an, LED, input value, blank_mask, err_mask, frame_valid);
    modport slave  (input an, LED, output value, blank_mask, err_mask, frame_valid);
endinterface

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: rebuilds a 16-bit hex value from a multiplexed active-low 4-digit seven-segment bus
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    seg7_scan_reader_if.slave bus
);
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [7:0]  run;
    logic [3:0]  got;
    logic [15:0] sh_val;
    logic [3:0]  sh_blk;
    logic [3:0]  sh_err;
    logic        match;
    logic        capture;
    logic [1:0]  sel;
    logic [3:0]  dec_nib;
    logic        dec_blk;
    logic        dec_err;
    logic [3:0]  got_nxt;
    logic [15:0] val_nxt;
    logic [3:0]  blk_nxt;
    logic [3:0]  err_nxt;

    assign match   = ({bus.an, bus.LED} == {an_q, seg_q}) && $onehot(~bus.an);
    assign capture = match && (run == 8'(STABLE_CYCLES - 1));
    assign sel     = !an_q[0] ? 2'd0 : !an_q[1] ? 2'd1 : !an_q[2] ? 2'd2 : 2'd3;

    always_comb begin
        dec_nib = 4'h0;
        dec_blk = 1'b0;
        dec_err = 1'b0;
        case (seg_q)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0001100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            7'b1111111: dec_blk = 1'b1;
            default:    dec_err = 1'b1;
        endcase
    end

    // Shadow contents with the digit being captured merged in, so a completing frame needs no extra cycle
    always_comb begin
        val_nxt = sh_val;
        blk_nxt = sh_blk;
        err_nxt = sh_err;
        val_nxt[4*sel +: 4] = dec_nib;
        blk_nxt[sel] = dec_blk;
        err_nxt[sel] = dec_err;
        got_nxt = got | (4'b0001 << sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q            <= 4'hF;
            seg_q           <= 7'h7F;
            run             <= 8'd0;
            got             <= 4'h0;
            sh_val          <= 16'h0;
            sh_blk          <= 4'h0;
            sh_err          <= 4'h0;
            bus.value       <= 16'h0;
            bus.blank_mask  <= 4'h0;
            bus.err_mask    <= 4'h0;
            bus.frame_valid <= 1'b0;
        end else begin
            an_q            <= bus.an;
            seg_q           <= bus.LED;
            run             <= !match ? 8'd0 : (run == 8'(STABLE_CYCLES)) ? run : run + 8'd1;
            bus.frame_valid <= 1'b0;
            if (capture) begin
                sh_val <= val_nxt;
                sh_blk <= blk_nxt;
                sh_err <= err_nxt;
                if (got_nxt == 4'hF) begin
                    bus.value       <= val_nxt;
                    bus.blank_mask  <= blk_nxt;
                    bus.err_mask    <= err_nxt;
                    bus.frame_valid <= 1'b1;
                    got             <= 4'h0;
                end else begin
                    got <= got_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: scenario tasks drive scans; a frame scoreboard checks every frame_valid pulse
module tb_seg7_scan_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int frames = 0;
    logic [23:0] exp_q [$];

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;

    seg7_scan_reader_if bus ();
    seg7_scan_reader #(.STABLE_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid) begin
            frames++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_frame: got value=%h blank=%b err=%b, required no frame",
                         bus.value, bus.blank_mask, bus.err_mask);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({bus.value, bus.blank_mask, bus.err_mask} !== e) begin
                    miscompares++;
                    $display("FAIL frame: got value=%h blank=%b err=%b, required value=%h blank=%b err=%b",
                             bus.value, bus.blank_mask, bus.err_mask, e[23:8], e[7:4], e[3:0]);
                end
            end
        end
    end

    task automatic show(input logic [3:0] a, input logic [6:0] l, input int n);
        bus.an = a;
        bus.LED = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        show(4'hF, BLANK, n);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        vectors++;
        if ({bus.value, bus.blank_mask, bus.err_mask, bus.frame_valid} !== 25'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b, required all zero",
                     bus.value, bus.blank_mask, bus.err_mask, bus.frame_valid);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_full_frame;
        int f0 = frames;
        exp_q.push_back({16'hC0DE, 4'h0, 4'h0});
        show(D0, SEG[14], 8);
        show(D1, SEG[13], 8);
        show(D2, SEG[0], 8);
        show(D3, SEG[12], 4);
        vectors++;
        if (bus.frame_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_early: frame_valid=%b before edge 4, required 0", bus.frame_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.frame_valid !== 1'b1 || bus.value !== 16'hC0DE) begin
            miscompares++;
            $display("FAIL full_edge4: frame_valid=%b value=%h, required 1 and c0de", bus.frame_valid, bus.value);
        end
        repeat (3) @(negedge clk);
        idle(3);
        vectors++;
        if (frames - f0 != 1) begin
            miscompares++;
            $display("FAIL full_count: %0d frames, required 1", frames - f0);
        end
    endtask

    task automatic test_glitch;
        int f0 = frames;
        for (int i = 0; i < 4; i++) show(~(4'b0001 << i), SEG[i+1], 4);
        idle(3);
        vectors++;
        if (frames != f0) begin
            miscompares++;
            $display("FAIL glitch_short: %0d frames, required 0", frames - f0);
        end
        exp_q.push_back({16'h4321, 4'h0, 4'h0});
        for (int i = 0; i < 4; i++) show(~(4'b0001 << i), SEG[i+1], 5);
        idle(3);
        vectors++;
        if (frames - f0 != 1) begin
            miscompares++;
            $display("FAIL glitch_long: %0d frames, required 1", frames - f0);
        end
    endtask

    task automatic test_blank_err;
        int f0 = frames;
        exp_q.push_back({16'h0707, 4'b1000, 4'b0010});
        show(D0, SEG[7], 6);
        show(D1, 7'b1111110, 6);
        show(D2, SEG[7], 6);
        show(D3, BLANK, 6);
        idle(3);
        vectors++;
        if (frames - f0 != 1) begin
            miscompares++;
            $display("FAIL blank_err_count: %0d frames, required 1", frames - f0);
        end
    endtask

    task automatic test_illegal_anodes;
        int f0 = frames;
        show(D0, SEG[9], 6);
        show(D1, SEG[10], 6);
        show(4'b1100, SEG[8], 20);
        show(4'b1111, SEG[8], 20);
        vectors++;
        if (frames != f0 || bus.value !== 16'h0707) begin
            miscompares++;
            $display("FAIL illegal_hold: %0d frames value=%h, required 0 and 0707", frames - f0, bus.value);
        end
        exp_q.push_back({16'hFBA9, 4'h0, 4'h0});
        show(D2, SEG[11], 6);
        show(D3, SEG[15], 6);
        idle(3);
        vectors++;
        if (frames - f0 != 1) begin
            miscompares++;
            $display("FAIL illegal_count: %0d frames, required 1", frames - f0);
        end
    endtask

    task automatic test_reset_mid;
        int f0 = frames;
        show(D0, SEG[1], 6);
        show(D1, SEG[2], 6);
        show(D2, SEG[3], 6);
        bus.an = 4'hF;
        bus.LED = BLANK;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({bus.value, bus.blank_mask, bus.err_mask, bus.frame_valid} !== 25'h0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h/%b/%b/%b, required all zero",
                     bus.value, bus.blank_mask, bus.err_mask, bus.frame_valid);
        end
        show(D3, SEG[4], 6);
        idle(2);
        vectors++;
        if (frames != f0 || bus.value !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid_partial: %0d frames value=%h, required 0 and 0000", frames - f0, bus.value);
        end
        exp_q.push_back({16'h4321, 4'h0, 4'h0});
        show(D0, SEG[1], 6);
        show(D1, SEG[2], 6);
        show(D2, SEG[3], 6);
        idle(3);
        vectors++;
        if (frames - f0 != 1) begin
            miscompares++;
            $display("FAIL reset_mid_count: %0d frames, required 1", frames - f0);
        end
    endtask

    task automatic test_recapture;
        int f0 = frames;
        exp_q.push_back({16'hAAA5, 4'h0, 4'h0});
        show(D0, SEG[1], 6);
        show(D0, SEG[5], 6);
        show(D1, SEG[10], 6);
        show(D2, SEG[10], 6);
        show(D3, SEG[10], 6);
        idle(3);
        vectors++;
        if (frames - f0 != 1) begin
            miscompares++;
            $display("FAIL recapture_count: %0d frames, required 1", frames - f0);
        end
    endtask

    task automatic test_reverse_order;
        int f0 = frames;
        exp_q.push_back({16'hFEDC, 4'h0, 4'h0});
        show(D3, SEG[15], 6);
        show(D2, SEG[14], 6);
        show(D1, SEG[13], 6);
        show(D0, SEG[12], 6);
        idle(3);
        vectors++;
        if (frames - f0 != 1 || bus.value !== 16'hFEDC) begin
            miscompares++;
            $display("FAIL reverse: %0d frames value=%h, required 1 and fedc", frames - f0, bus.value);
        end
    endtask

    initial begin
        bus.an = 4'hF;
        bus.LED = BLANK;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_glitch();
        test_blank_err();
        test_illegal_anodes();
        test_reset_mid();
        test_recapture();
        test_reverse_order();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_frames: %0d expected frames never produced, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

- Reads a multiplexed, active-low 4-digit seven-segment bus (anode enables plus segment lines) and reconstructs the displayed 16-bit hex value.
- Sits at the receiving end of the display drive path, using the same segment encoding as the team's hex-to-segment decoder.
- Used for self-check and loopback of display drivers.
- Filters digit-switching glitches with a stability window and flags blank and unrecognised patterns per digit.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted; legal range 2..255.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- an  in  4  anode enables, active-low; an[i]=0 selects digit i.
- LED  in  7  segment bus, active-low, bit6=a … bit0=g.
- value  out  16  last complete frame; digit i occupies value[4i+3:4i].
- blank_mask  out  4  bit i set when digit i was all-off (7'b1111111) in the last frame.
- err_mask  out  4  bit i set when digit i carried an unrecognised pattern in the last frame.
- frame_valid  out  1  one-cycle pulse when value/blank_mask/err_mask update.

## Operation
- Encoding, LED pattern → nibble:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0001100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - 1111111 → blank (nibble 0, blank bit).
  - Any other pattern → error (nibble 0, err bit).
- Input stage: an and LED are registered into an_q/seg_q every cycle.
- Run counter `run` (8 bits, saturates at STABLE_CYCLES), updated each edge:
  - Increment when {an,LED}=={an_q,seg_q} and an has exactly one zero bit.
  - Otherwise clear to 0.
- Capture: fires on the edge where run goes from STABLE_CYCLES-1 to STABLE_CYCLES; exactly once per dwell.
  - Decodes seg_q into the shadow nibble, shadow blank bit and shadow err bit for the selected digit.
  - Sets that digit's bit in `got[3:0]`.
- Re-capture of a digit already in got (the same or a new value) overwrites its shadow slot and does not complete a frame.
- Frame completion:
  - When a capture makes got==4'b1111, on that same edge value, blank_mask and err_mask load the shadow contents, including the just-captured digit.
  - frame_valid=1 for that one cycle; got clears to 0.
- Frames are assembled regardless of scan order.
- an with zero or multiple low bits:
  - Never captures.
  - Does not clear got or the shadow slots.
- Outputs hold between frames.

## Timing
- Reset values:
  - value=0, blank_mask=0, err_mask=0, frame_valid=0.
  - run=0, got=0, shadow=0.
  - an_q=4'hF, seg_q=7'h7F.
- Reset asserted mid-frame discards partial captures; first frame after release needs all four digits again.
- Capture latency: with a stable input first present before edge E0, capture happens at edge E0+STABLE_CYCLES.
  - Dwell ≥ STABLE_CYCLES+1 cycles → captured.
  - Dwell ≤ STABLE_CYCLES cycles → ignored.
- Frame latency: frame_valid and new value are visible after the capture edge of the last missing digit; no extra pipeline cycle.
- A segment change while an is held restarts the run.
  - The new pattern is captured after its own full dwell.
  - The earlier capture in the same dwell stands.
- Pure combinational paths from inputs to outputs: none.

## Test plan
- Full frame: STABLE_CYCLES=4, scan an=1110/1101/1011/0111 with LED=E(0110000)/d(1000010)/0(0000001)/C(0110001), 8 cycles each.
  - Required: single frame_valid pulse, value=16'hC0DE, masks 0.
  - Pulse at edge 4 of the 0111 dwell.
- Glitch rejection: each digit held 4 cycles (one short), then 5 cycles.
  - Required: no capture or frame_valid during the 4-cycle pass.
  - Frame completes on the 5-cycle pass.
- Blank/error: digit 3 LED=1111111, digit 1 LED=1111110, others '7' (0001111).
  - Required: value=16'h0707, blank_mask=4'b1000, err_mask=4'b0010.
- Illegal anodes: an=1100 or 1111 held 20 cycles between captures of digits 0/1 and 2/3.
  - Required: no capture, got preserved, frame completes with correct value once digits 2 and 3 are shown.
- Reset mid-frame: capture digits 0-2, pulse reset for 1 cycle, then show only digit 3.
  - Required: all outputs 0, no frame_valid until digits 0-2 are re-captured.
- Re-capture: digit 0 shown as '1', then '5', then digits 1-3 as 'A'.
  - Required: value=16'hAAA5, frame_valid exactly once.
